multi_core_dispatcher: RTL and testbench

Job-level scheduler for an array of N CNN core units. It accepts a stream of inference jobs over a valid/ready handshake and dispatches each one to the lowest-indexed idle core with a one-cycle start pulse. It collects per-core results with round-robin arbitration onto one valid/ready result stream and aborts hung cores after a watchdog timeout. It replaces the fixed start-all/wait-all controller with continuous, out-of-order job flow.

---
 rtl/multi_core_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_multi_core_dispatcher.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_core_dispatcher.sv
// Job scheduler for N CNN cores: dispatches jobs to the lowest idle core, collects
// results round-robin onto one valid/ready stream, and aborts cores that hang.
module multi_core_dispatcher #(
   parameter  int N_CORES  = 4,
   parameter  int RESULT_W = 32,
   parameter  int JOB_ID_W = 8,
   parameter  int TIMEOUT  = 1024,
   localparam int CORE_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1,
   localparam int CNT_W    = $clog2(N_CORES + 1),
   localparam int WD_W     = $clog2(TIMEOUT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         job_valid,
   input  logic [JOB_ID_W-1:0]          job_id,
   output logic                         job_ready,
   output logic [N_CORES-1:0]           core_start,
   output logic [N_CORES-1:0]           core_abort,
   output logic [N_CORES*JOB_ID_W-1:0]  core_job_id,
   input  logic [N_CORES-1:0]           core_done,
   input  logic [N_CORES*RESULT_W-1:0]  core_result,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [RESULT_W-1:0]          res_data,
   output logic [JOB_ID_W-1:0]          res_job_id,
   output logic [CORE_W-1:0]            res_core,
   output logic                         res_err,
   output logic [CNT_W-1:0]             busy_count,
   output logic                         all_idle
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; ready never depends on valid, and valid/data hold until the transfer.

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_HELD = 2'd2;

   logic [1:0]                  r_state     [N_CORES];
   logic [1:0]                  w_state_nxt [N_CORES];
   logic [WD_W-1:0]             r_wd        [N_CORES];
   logic [RESULT_W-1:0]         r_hold_data [N_CORES];
   logic [N_CORES-1:0]          r_hold_err;
   logic [N_CORES-1:0]          r_start;
   logic [N_CORES-1:0]          r_abort;
   logic [N_CORES*JOB_ID_W-1:0] r_job_id;
   logic [CORE_W-1:0]           r_ptr;
   logic                        r_res_valid;
   logic [RESULT_W-1:0]         r_res_data;
   logic [JOB_ID_W-1:0]         r_res_job_id;
   logic [CORE_W-1:0]           r_res_core;
   logic                        r_res_err;
   logic [CNT_W-1:0]            r_busy_cnt;

   logic [N_CORES-1:0]          w_idle;
   logic [N_CORES-1:0]          w_done_ok;
   logic [N_CORES-1:0]          w_timeout;
   logic [N_CORES-1:0]          w_disp_onehot;
   logic [CORE_W-1:0]           w_disp_idx;
   logic                        w_accept;
   logic                        w_load;
   logic                        w_sel_found;
   logic [CORE_W-1:0]           w_sel_idx;
   logic [CNT_W-1:0]            w_cnt_nxt;

   always_comb begin
      w_idle    = '0;
      w_done_ok = '0;
      w_timeout = '0;
      for (int k = 0; k < N_CORES; k++) begin
         w_idle[k]    = (r_state[k] == S_IDLE);
         // A done pulse coinciding with the start pulse belongs to no job yet.
         w_done_ok[k] = (r_state[k] == S_BUSY) && !r_start[k] && core_done[k];
         w_timeout[k] = (r_state[k] == S_BUSY) && !w_done_ok[k] &&
                        (r_wd[k] == WD_W'(TIMEOUT - 1));
      end
   end

   assign job_ready = |w_idle;
   assign w_accept  = job_valid && job_ready;
   assign w_load    = !r_res_valid || res_ready;

   always_comb begin
      w_disp_idx = '0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         if (w_idle[k]) w_disp_idx = CORE_W'(k);
      end
      w_disp_onehot = w_accept ? (N_CORES'(1) << w_disp_idx) : '0;
   end

   // First HELD core at or after the round-robin pointer, wrapping.
   always_comb begin : sel_blk
      int j;
      j           = 0;
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      for (int i = 0; i < N_CORES; i++) begin
         j = int'(r_ptr) + i;
         if (j >= N_CORES) j = j - N_CORES;
         if (!w_sel_found && (r_state[j] == S_HELD)) begin
            w_sel_found = 1'b1;
            w_sel_idx   = CORE_W'(j);
         end
      end
   end

   always_comb begin
      w_cnt_nxt = '0;
      for (int k = 0; k < N_CORES; k++) begin
         w_state_nxt[k] = r_state[k];
         case (r_state[k])
            S_IDLE:  if (w_disp_onehot[k]) w_state_nxt[k] = S_BUSY;
            S_BUSY:  if (w_done_ok[k] || w_timeout[k]) w_state_nxt[k] = S_HELD;
            S_HELD:  if (w_load && w_sel_found && (w_sel_idx == CORE_W'(k)))
                        w_state_nxt[k] = S_IDLE;
            default: w_state_nxt[k] = S_IDLE;
         endcase
         if (w_state_nxt[k] != S_IDLE) w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_CORES; k++) begin
            r_state[k]     <= S_IDLE;
            r_wd[k]        <= '0;
            r_hold_data[k] <= '0;
         end
         r_hold_err   <= '0;
         r_start      <= '0;
         r_abort      <= '0;
         r_job_id     <= '0;
         r_ptr        <= '0;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_res_job_id <= '0;
         r_res_core   <= '0;
         r_res_err    <= 1'b0;
         r_busy_cnt   <= '0;
      end else begin
         r_start    <= w_disp_onehot;
         r_abort    <= w_timeout;
         r_busy_cnt <= w_cnt_nxt;
         for (int k = 0; k < N_CORES; k++) begin
            r_state[k] <= w_state_nxt[k];
            if (w_disp_onehot[k]) begin
               r_job_id[k*JOB_ID_W +: JOB_ID_W] <= job_id;
               r_wd[k]                          <= '0;
            end else if (r_state[k] == S_BUSY) begin
               r_wd[k] <= r_wd[k] + WD_W'(1);
            end
            if (w_done_ok[k]) begin
               r_hold_data[k] <= core_result[k*RESULT_W +: RESULT_W];
               r_hold_err[k]  <= 1'b0;
            end else if (w_timeout[k]) begin
               r_hold_data[k] <= '0;
               r_hold_err[k]  <= 1'b1;
            end
         end
         // The tag stays in r_job_id while HELD since only IDLE cores are dispatched.
         if (w_load) begin
            if (w_sel_found) begin
               r_res_valid  <= 1'b1;
               r_res_data   <= r_hold_data[w_sel_idx];
               r_res_job_id <= r_job_id[w_sel_idx*JOB_ID_W +: JOB_ID_W];
               r_res_core   <= w_sel_idx;
               r_res_err    <= r_hold_err[w_sel_idx];
               if (int'(w_sel_idx) == N_CORES - 1) r_ptr <= '0;
               else                                r_ptr <= w_sel_idx + CORE_W'(1);
            end else begin
               r_res_valid <= 1'b0;
            end
         end
      end
   end

   assign core_start  = r_start;
   assign core_abort  = r_abort;
   assign core_job_id = r_job_id;
   assign res_valid   = r_res_valid;
   assign res_data    = r_res_data;
   assign res_job_id  = r_res_job_id;
   assign res_core    = r_res_core;
   assign res_err     = r_res_err;
   assign busy_count  = r_busy_cnt;
   assign all_idle    = (r_busy_cnt == '0) && !r_res_valid;

endmodule

// File: tb/tb_multi_core_dispatcher.sv
// Directed bench for multi_core_dispatcher: expected results are queued as jobs
// complete and a monitor pops and compares every result handshake.
module tb_multi_core_dispatcher;

   localparam int EXP_W = 1 + 2 + 8 + 32;

   logic         clk;
   logic         rst;
   logic         job_valid;
   logic [7:0]   job_id;
   logic         job_ready;
   logic [3:0]   core_start;
   logic [3:0]   core_abort;
   logic [31:0]  core_job_id;
   logic [3:0]   core_done;
   logic [127:0] core_result;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  res_data;
   logic [7:0]   res_job_id;
   logic [1:0]   res_core;
   logic         res_err;
   logic [2:0]   busy_count;
   logic         all_idle;

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_err    = 0;

   multi_core_dispatcher #(
      .N_CORES(4), .RESULT_W(32), .JOB_ID_W(8), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_id(job_id), .job_ready(job_ready),
      .core_start(core_start), .core_abort(core_abort), .core_job_id(core_job_id),
      .core_done(core_done), .core_result(core_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_job_id(res_job_id), .res_core(res_core), .res_err(res_err),
      .busy_count(busy_count), .all_idle(all_idle)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no end of test, expected finish before 200000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void push_exp(input logic err, input logic [1:0] core,
                                    input logic [7:0] id, input logic [31:0] data);
      exp_q.push_back({err, core, id, data});
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      job_valid = 1'b0;
      core_done = '0;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Driver: n jobs back-to-back into an all-idle array, starts on cores 0..n-1.
   task automatic send_burst(input logic [7:0] base, input int n);
      job_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         job_id = base + 8'(i);
         check("job_ready_burst", job_ready, 1);
         tick();
         check("start_onehot", core_start, 64'(1) << i);
      end
      job_valid = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [EXP_W-1:0] got;
      logic [EXP_W-1:0] exp;
      if (!rst && res_valid && res_ready) begin
         got = {res_err, res_core, res_job_id, res_data};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL res_unexpected: got err=%0d core=%0d id=%02h data=%08h expected no result",
                     res_err, res_core, res_job_id, res_data);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               n_err++;
               $display("FAIL res_stream: got err=%0d core=%0d id=%02h data=%08h expected err=%0d core=%0d id=%02h data=%08h",
                        got[42], got[41:40], got[39:32], got[31:0],
                        exp[42], exp[41:40], exp[39:32], exp[31:0]);
            end
         end
      end
   end

   initial begin
      rst         = 1'b1;
      job_valid   = 1'b0;
      job_id      = '0;
      core_done   = '0;
      core_result = '0;
      res_ready   = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_job_ready", job_ready, 1);
      check("rst_busy_count", busy_count, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_all_idle", all_idle, 1);
      check("rst_core_job_id", core_job_id, 0);

      // single job on core 0
      send_burst(8'h11, 1);
      check("s1_busy_count", busy_count, 1);
      tick();
      check("s1_start_once", core_start, 0);
      repeat (3) tick();
      core_done[0]          = 1'b1;
      core_result[31:0]     = 32'hDEADBEEF;
      push_exp(1'b0, 2'd0, 8'h11, 32'hDEADBEEF);
      tick();
      core_done = '0;
      tick();
      check("s1_res_latency", res_valid, 1);
      tick();
      check("s1_all_idle", all_idle, 1);

      // five jobs, four cores
      do_reset();
      job_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         job_id = 8'h20 + 8'(i);
         tick();
         check("s2_start", core_start, 64'(1) << i);
      end
      job_id = 8'h24;
      check("s2_job_ready_full", job_ready, 0);
      tick();
      check("s2_fifth_held", core_start, 0);
      check("s2_busy_count", busy_count, 4);
      core_done[2]        = 1'b1;
      core_result[95:64]  = 32'h22220000;
      push_exp(1'b0, 2'd2, 8'h22, 32'h22220000);
      tick();
      core_done = '0;
      check("s2_job_ready_held", job_ready, 0);
      tick();
      check("s2_job_ready_freed", job_ready, 1);
      tick();
      job_valid = 1'b0;
      check("s2_fifth_start", core_start, 4'b0100);
      check("s2_fifth_tag", core_job_id[23:16], 8'h24);
      tick();

      // round robin: cores 1,2 then 3,0
      do_reset();
      send_burst(8'h30, 4);
      tick();
      core_done           = 4'b0110;
      core_result[63:32]  = 32'h11110001;
      core_result[95:64]  = 32'h22220002;
      push_exp(1'b0, 2'd1, 8'h31, 32'h11110001);
      push_exp(1'b0, 2'd2, 8'h32, 32'h22220002);
      tick();
      core_done = '0;
      tick();
      check("s3_first_core", res_core, 1);
      tick();
      check("s3_second_core", res_core, 2);
      tick();
      core_done           = 4'b1001;
      core_result[31:0]   = 32'h0000AAAA;
      core_result[127:96] = 32'h3333BBBB;
      push_exp(1'b0, 2'd3, 8'h33, 32'h3333BBBB);
      push_exp(1'b0, 2'd0, 8'h30, 32'h0000AAAA);
      tick();
      core_done = '0;
      tick();
      check("s3_ptr_wrap_core", res_core, 3);
      repeat (2) tick();
      check("s3_all_idle", all_idle, 1);

      // back-pressure with three results pending
      do_reset();
      res_ready = 1'b0;
      send_burst(8'h40, 3);
      tick();
      core_done          = 4'b0111;
      core_result[31:0]  = 32'h40000000;
      core_result[63:32] = 32'h40000001;
      core_result[95:64] = 32'h40000002;
      push_exp(1'b0, 2'd0, 8'h40, 32'h40000000);
      push_exp(1'b0, 2'd1, 8'h41, 32'h40000001);
      push_exp(1'b0, 2'd2, 8'h42, 32'h40000002);
      tick();
      core_done = '0;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("s4_hold_valid", res_valid, 1);
         check("s4_hold_data", res_data, 32'h40000000);
         check("s4_hold_core", res_core, 0);
         check("s4_hold_busy", busy_count, 2);
         tick();
      end
      res_ready = 1'b1;
      repeat (4) tick();
      check("s4_all_idle", all_idle, 1);

      // watchdog on core 3, then done exactly on the timeout edge
      do_reset();
      send_burst(8'h50, 4);
      tick();
      core_done          = 4'b0111;
      core_result[31:0]  = 32'h50000000;
      core_result[63:32] = 32'h50000001;
      core_result[95:64] = 32'h50000002;
      push_exp(1'b0, 2'd0, 8'h50, 32'h50000000);
      push_exp(1'b0, 2'd1, 8'h51, 32'h50000001);
      push_exp(1'b0, 2'd2, 8'h52, 32'h50000002);
      push_exp(1'b1, 2'd3, 8'h53, 32'h00000000);
      tick();
      core_done = '0;
      repeat (13) tick();
      check("s5_no_early_abort", core_abort, 0);
      tick();
      check("s5_abort_pulse", core_abort, 4'b1000);
      check("s5_busy_held", busy_count, 1);
      tick();
      check("s5_abort_once", core_abort, 0);
      send_burst(8'h60, 1);
      repeat (15) tick();
      core_done[0]      = 1'b1;
      core_result[31:0] = 32'h0000600D;
      push_exp(1'b0, 2'd0, 8'h60, 32'h0000600D);
      tick();
      core_done = '0;
      check("s5_done_wins", core_abort, 0);
      tick();
      check("s5_done_wins_next", core_abort, 0);
      tick();

      // reset with two BUSY and one HELD core
      do_reset();
      res_ready = 1'b0;
      send_burst(8'h70, 4);
      tick();
      core_done = 4'b0011;
      tick();
      core_done = '0;
      tick();
      check("s6_pre_busy", busy_count, 3);
      check("s6_pre_valid", res_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("s6_busy_count", busy_count, 0);
      check("s6_res_valid", res_valid, 0);
      check("s6_job_ready", job_ready, 1);
      check("s6_start", core_start, 0);
      check("s6_abort", core_abort, 0);
      check("s6_all_idle", all_idle, 1);
      tick();
      check("s6_start_after", core_start, 0);
      check("s6_abort_after", core_abort, 0);
      res_ready = 1'b1;
      tick();

      check("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
